ucdp_afifo_rdburst: RTL and testbench

Read-side burst scheduler placed directly downstream of the async FIFO's target port, in the target clock domain.
- Watches FIFO fill level and pops words only in bursts, once a threshold is reached or a timeout expires.
- Presents popped words on a valid/ready stream with per-burst "last" framing.
- Decouples FIFO pop timing from consumer backpressure via a 2-entry output buffer.

---
 rtl/ucdp_afifo_rdburst_pkg.sv | 11 +
 rtl/ucdp_skid2.sv | 59 +++++
 rtl/ucdp_afifo_rdburst.sv | 141 ++++++++++++++
 tb/tb_ucdp_afifo_rdburst.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucdp_afifo_rdburst_pkg.sv
// Shared types and constants for the async-FIFO read-side burst scheduler.
package ucdp_afifo_rdburst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned STAT_WIDTH = 16;

endpackage

// File: rtl/ucdp_skid2.sv
// Two-entry valid/ready buffer; entry 0 is always the head presented downstream.
module ucdp_skid2 #(
  parameter int unsigned width_p = 9
) (
  input  logic               clk_i,
  input  logic               rst_an_i,
  input  logic               push_i,
  input  logic [width_p-1:0] push_data_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         cnt_o
);

  logic [width_p-1:0] ent0_r;
  logic [width_p-1:0] ent1_r;
  logic [1:0]         cnt_r;
  logic               xfer;

  assign xfer    = (cnt_r != 2'd0) & ready_i;
  assign valid_o = (cnt_r != 2'd0);
  assign data_o  = ent0_r;
  assign cnt_o   = cnt_r;

  // Upstream never pushes into a full buffer, so a push with cnt==2 only happens alongside a transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case ({push_i, xfer})
        2'b11: begin
          if (cnt_r == 2'd2) begin
            ent0_r <= ent1_r;
            ent1_r <= push_data_i;
          end else begin
            ent0_r <= push_data_i;
          end
        end
        2'b01: begin
          ent0_r <= ent1_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b10: begin
          if (cnt_r == 2'd0) begin
            ent0_r <= push_data_i;
            cnt_r  <= 2'd1;
          end else if (cnt_r == 2'd1) begin
            ent1_r <= push_data_i;
            cnt_r  <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ucdp_afifo_rdburst.sv
// Burst read scheduler downstream of the async FIFO target port.
// Optional statistics counters: define UCDP_AFIFO_RDBURST_STAT_EN.
//
// state | meaning
// IDLE  | waiting for fill level >= threshold or non-empty timeout
// BURST | popping up to rem_r words into the output buffer
module ucdp_afifo_rdburst
  import ucdp_afifo_rdburst_pkg::*;
#(
  parameter int unsigned dwidth_p    = 8,
  parameter int unsigned awidth_p    = 4,
  parameter int unsigned tmo_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_an_i,
  input  logic                   fifo_empty_i,
  input  logic [dwidth_p-1:0]    fifo_rd_data_i,
  input  logic [awidth_p-1:0]    fifo_data_avail_i,
  output logic                   fifo_rd_en_o,
  input  logic [awidth_p-1:0]    cfg_thresh_i,
  input  logic [awidth_p-1:0]    cfg_maxlen_i,
  input  logic [tmo_width_p-1:0] cfg_tmo_i,
  output logic                   strm_valid_o,
  input  logic                   strm_ready_i,
  output logic [dwidth_p-1:0]    strm_data_o,
  output logic                   strm_last_o,
  output logic                   busy_o
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
  ,
  input  logic                   stat_clr_i,
  output logic [STAT_WIDTH-1:0]  stat_bursts_o,
  output logic [STAT_WIDTH-1:0]  stat_tmo_o
`endif
);

  localparam logic [awidth_p-1:0]    ONE_A = {{(awidth_p-1){1'b0}}, 1'b1};
  localparam logic [tmo_width_p-1:0] ONE_T = {{(tmo_width_p-1){1'b0}}, 1'b1};

  state_e                 state_r;
  state_e                 state_nxt;
  logic [awidth_p-1:0]    rem_r;
  logic [tmo_width_p-1:0] tmo_cnt_r;
  logic [awidth_p-1:0]    thresh_eff;
  logic [awidth_p-1:0]    maxlen_eff;
  logic [awidth_p-1:0]    len_snap;
  logic                   thr_hit;
  logic                   tmo_hit;
  logic                   start;
  logic                   pop;
  logic [1:0]             buf_cnt;
  logic [dwidth_p:0]      buf_out;

  assign thresh_eff = (cfg_thresh_i == '0) ? ONE_A : cfg_thresh_i;
  assign maxlen_eff = (cfg_maxlen_i == '0) ? ONE_A : cfg_maxlen_i;
  assign len_snap   = (fifo_data_avail_i < maxlen_eff) ? fifo_data_avail_i : maxlen_eff;
  assign thr_hit    = (fifo_data_avail_i >= thresh_eff);
  assign tmo_hit    = !fifo_empty_i & (cfg_tmo_i != '0) & (tmo_cnt_r == (cfg_tmo_i - ONE_T));

  always_comb begin
    state_nxt = state_r;
    start     = 1'b0;
    pop       = 1'b0;
    case (state_r)
      IDLE: begin
        if (thr_hit || tmo_hit) begin
          start     = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        // Gated by reset so a burst interrupted by reset never pops in that cycle.
        pop = rst_an_i & !fifo_empty_i & (rem_r != '0) & (buf_cnt != 2'd2);
        if (pop && (rem_r == ONE_A)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_an_i) begin
      state_r   <= IDLE;
      rem_r     <= '0;
      tmo_cnt_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (start) begin
        rem_r <= len_snap;
      end else if (pop) begin
        rem_r <= rem_r - ONE_A;
      end
      if ((state_r != IDLE) || fifo_empty_i || start) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != '1) begin
        tmo_cnt_r <= tmo_cnt_r + ONE_T;
      end
    end
  end

  ucdp_skid2 #(
    .width_p (dwidth_p + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_an_i    (rst_an_i),
    .push_i      (pop),
    .push_data_i ({(rem_r == ONE_A), fifo_rd_data_i}),
    .ready_i     (strm_ready_i),
    .valid_o     (strm_valid_o),
    .data_o      (buf_out),
    .cnt_o       (buf_cnt)
  );

  assign fifo_rd_en_o = pop;
  assign strm_last_o  = buf_out[dwidth_p];
  assign strm_data_o  = buf_out[dwidth_p-1:0];
  assign busy_o       = (state_r == BURST) | (buf_cnt != 2'd0);

`ifdef UCDP_AFIFO_RDBURST_STAT_EN
  logic [STAT_WIDTH-1:0] stat_bursts_r;
  logic [STAT_WIDTH-1:0] stat_tmo_r;

  always_ff @(posedge clk_i) begin
    if (!rst_an_i || stat_clr_i) begin
      stat_bursts_r <= '0;
      stat_tmo_r    <= '0;
    end else begin
      if (start && (stat_bursts_r != '1)) begin
        stat_bursts_r <= stat_bursts_r + 1'b1;
      end
      if (start && !thr_hit && (stat_tmo_r != '1)) begin
        stat_tmo_r <= stat_tmo_r + 1'b1;
      end
    end
  end

  assign stat_bursts_o = stat_bursts_r;
  assign stat_tmo_o    = stat_tmo_r;
`endif

endmodule

// File: tb/tb_ucdp_afifo_rdburst.sv
// Directed/table-driven bench for ucdp_afifo_rdburst with a behavioural FIFO and in-order scoreboard.
module tb_ucdp_afifo_rdburst;

  logic       clk_i = 1'b0;
  logic       rst_an_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_rd_data_i;
  logic [3:0] fifo_data_avail_i;
  logic       fifo_rd_en_o;
  logic [3:0] cfg_thresh_i;
  logic [3:0] cfg_maxlen_i;
  logic [7:0] cfg_tmo_i;
  logic       strm_valid_o;
  logic       strm_ready_i;
  logic [7:0] strm_data_o;
  logic       strm_last_o;
  logic       busy_o;
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
  logic        stat_clr_i;
  logic [15:0] stat_bursts_o;
  logic [15:0] stat_tmo_o;
`endif

  ucdp_afifo_rdburst #(
    .dwidth_p    (8),
    .awidth_p    (4),
    .tmo_width_p (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_an_i          (rst_an_i),
    .fifo_empty_i      (fifo_empty_i),
    .fifo_rd_data_i    (fifo_rd_data_i),
    .fifo_data_avail_i (fifo_data_avail_i),
    .fifo_rd_en_o      (fifo_rd_en_o),
    .cfg_thresh_i      (cfg_thresh_i),
    .cfg_maxlen_i      (cfg_maxlen_i),
    .cfg_tmo_i         (cfg_tmo_i),
    .strm_valid_o      (strm_valid_o),
    .strm_ready_i      (strm_ready_i),
    .strm_data_o       (strm_data_o),
    .strm_last_o       (strm_last_o),
    .busy_o            (busy_o)
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
    ,
    .stat_clr_i        (stat_clr_i),
    .stat_bursts_o     (stat_bursts_o),
    .stat_tmo_o        (stat_tmo_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int thresh;
    int maxlen;
    int tmo;
    int nwords;
    int exp_bursts;
    int exp_words;
    int exp_first;
    int exp_final;
    int exp_tmo_starts;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         burst_lens[$];
  int         total = 0;
  int         bad = 0;
  int         since_last = 0;
  int         delivered = 0;
  int         written = 0;
  logic [7:0] wr_val = 8'h10;
  logic       hide = 1'b0;
  logic       pop_s, val_s, last_s;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty_i      = (fifo_q.size() == 0) || hide;
    fifo_data_avail_i = 4'(fifo_q.size());
    fifo_rd_data_i    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(wr_val);
      wr_val++;
      written++;
    end
    fifo_drive();
  endtask

  // One clock: sample mid-low-phase, advance, update FIFO/scoreboard, return at the negedge.
  task automatic cyc();
    logic       v, r, l, p, rs;
    logic [7:0] d;
    logic [7:0] w;
    #1;
    rs = rst_an_i; p = fifo_rd_en_o; v = strm_valid_o; r = strm_ready_i;
    d = strm_data_o; l = strm_last_o;
    pop_s = p; val_s = v; last_s = l;
    if (rs) begin
      if (fifo_empty_i) chk("rd_en_when_empty", int'(p), 0);
      if (v) begin
        if (exp_q.size() == 0) chk("spurious_valid", int'(v), 0);
        else chk("strm_data_order", int'(d), int'(exp_q[0]));
      end
    end
    @(posedge clk_i);
    if (!rs) begin
      exp_q.delete();
      since_last = 0;
    end else if (v && r && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      delivered++;
      since_last++;
      if (l) begin
        burst_lens.push_back(since_last);
        since_last = 0;
      end
    end
    if (p && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      if (rs) exp_q.push_back(w);
    end
    @(negedge clk_i);
    fifo_drive();
  endtask

  task automatic do_reset();
    rst_an_i = 1'b0;
    hide = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    fifo_drive();
    cyc();
    cyc();
    rst_an_i = 1'b1;
    burst_lens.delete();
    since_last = 0;
    delivered = 0;
  endtask

  task automatic check_zero(input string tag);
    #1;
    chk({tag, "_valid"}, int'(strm_valid_o), 0);
    chk({tag, "_last"}, int'(strm_last_o), 0);
    chk({tag, "_data"}, int'(strm_data_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_rd_en"}, int'(fifo_rd_en_o), 0);
  endtask

  task automatic set_cfg(input int th, input int ml, input int tmo);
    cfg_thresh_i = 4'(th);
    cfg_maxlen_i = 4'(ml);
    cfg_tmo_i    = 8'(tmo);
  endtask

  initial begin
    int first_pop, first_valid, last_idx, vcnt, npop, maxb;
    bit drained;

    //          thr mx tmo  n  bursts words first final tmo_starts
    vecs[0] = '{4,  8,  0,  4, 1,     4,    4,    4,    0};
    vecs[1] = '{1,  3,  0,  7, 3,     7,    3,    1,    0};
    vecs[2] = '{0,  0,  0,  3, 3,     3,    1,    1,    0};
    vecs[3] = '{5,  8,  0,  4, 0,     0,    0,    0,    0};
    vecs[4] = '{8,  15, 0,  8, 1,     8,    8,    8,    0};
    vecs[5] = '{3,  2,  0,  5, 2,     4,    2,    2,    0};
    vecs[6] = '{9,  8,  0,  8, 0,     0,    0,    0,    0};
    vecs[7] = '{9,  8,  5,  3, 1,     3,    3,    3,    1};
    vecs[8] = '{2,  8,  3,  1, 1,     1,    1,    1,    1};

    rst_an_i = 1'b0;
    strm_ready_i = 1'b1;
    set_cfg(1, 8, 0);
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
    stat_clr_i = 1'b0;
`endif
    fifo_drive();
    @(negedge clk_i);
    do_reset();
    check_zero("reset_state");

    foreach (vecs[k]) begin
      do_reset();
      set_cfg(vecs[k].thresh, vecs[k].maxlen, vecs[k].tmo);
      strm_ready_i = 1'b1;
      load(vecs[k].nwords);
      for (int i = 0; i < 60; i++) cyc();
      chk($sformatf("vec%0d_bursts", k), burst_lens.size(), vecs[k].exp_bursts);
      chk($sformatf("vec%0d_words", k), delivered, vecs[k].exp_words);
      chk($sformatf("vec%0d_first_len", k),
          (burst_lens.size() > 0) ? burst_lens[0] : 0, vecs[k].exp_first);
      chk($sformatf("vec%0d_final_len", k),
          (burst_lens.size() > 0) ? burst_lens[burst_lens.size()-1] : 0, vecs[k].exp_final);
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
      chk($sformatf("vec%0d_stat_bursts", k), int'(stat_bursts_o), vecs[k].exp_bursts);
      chk($sformatf("vec%0d_stat_tmo", k), int'(stat_tmo_o), vecs[k].exp_tmo_starts);
`endif
    end

    // Threshold start latency and full rate.
    do_reset();
    set_cfg(4, 8, 0);
    load(4);
    first_pop = -1; first_valid = -1; last_idx = -1; vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (pop_s && first_pop < 0) first_pop = i;
      if (val_s && first_valid < 0) first_valid = i;
      if (val_s) vcnt++;
      if (val_s && last_s) last_idx = i;
    end
    chk("thr_first_pop", first_pop, 1);
    chk("thr_first_valid", first_valid, 2);
    chk("thr_valid_cycles", vcnt, 4);
    chk("thr_last_idx", last_idx, 5);

    // Timeout start.
    do_reset();
    set_cfg(6, 8, 10);
    load(2);
    first_pop = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pop_s && first_pop < 0) first_pop = i;
    end
    chk("tmo_first_pop", first_pop, 10);
    chk("tmo_burst_len", (burst_lens.size() == 1) ? burst_lens[0] : -1, 2);
`ifdef UCDP_AFIFO_RDBURST_STAT_EN
    chk("tmo_stat_tmo", int'(stat_tmo_o), 1);
    chk("tmo_stat_bursts", int'(stat_bursts_o), 1);
    stat_clr_i = 1'b1;
    cyc();
    stat_clr_i = 1'b0;
    chk("stat_clr_bursts", int'(stat_bursts_o), 0);
    chk("stat_clr_tmo", int'(stat_tmo_o), 0);
`endif

    // Backpressure mid-burst.
    do_reset();
    set_cfg(1, 8, 0);
    strm_ready_i = 1'b1;
    load(6);
    for (int i = 0; i < 4; i++) cyc();
    strm_ready_i = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_valid_held", int'(val_s), 1);
      chk("bp_last_held", int'(last_s), 0);
      chk("bp_no_pop", int'(pop_s), 0);
    end
    strm_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("bp_delivered", delivered, 6);
    chk("bp_one_burst_len", (burst_lens.size() == 1) ? burst_lens[0] : -1, 6);

    // Reset with three words of the burst still to pop.
    do_reset();
    set_cfg(1, 5, 0);
    strm_ready_i = 1'b1;
    load(5);
    for (int i = 0; i < 3; i++) cyc();
    rst_an_i = 1'b0;
    cyc();
    chk("rst_no_pop", int'(pop_s), 0);
    rst_an_i = 1'b1;
    check_zero("after_rst");
    delivered = 0;
    burst_lens.delete();
    for (int i = 0; i < 15; i++) cyc();
    chk("rst_post_delivered", delivered, 3);
    chk("rst_post_burst_len", (burst_lens.size() == 1) ? burst_lens[0] : -1, 3);

    // Random empty flag and backpressure.
    do_reset();
    set_cfg(3, 4, 6);
    written = 0;
    for (int i = 0; i < 10000; i++) begin
      if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back(wr_val);
        wr_val++;
        written++;
      end
      hide = ($urandom_range(0, 3) == 0);
      strm_ready_i = ($urandom_range(0, 3) != 0);
      fifo_drive();
      cyc();
    end
    hide = 1'b0;
    strm_ready_i = 1'b1;
    fifo_drive();
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      cyc();
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy_o) drained = 1'b1;
    end
    chk("rand_drained", int'(drained), 1);
    chk("rand_delivered", delivered, written);
    chk("rand_unterminated_words", since_last, 0);
    maxb = 0;
    npop = 0;
    foreach (burst_lens[j]) begin
      if (burst_lens[j] > maxb) maxb = burst_lens[j];
      npop += burst_lens[j];
    end
    chk("rand_burst_len_le_max", int'(maxb <= 4 && maxb > 0), 1);
    chk("rand_burst_sum", npop, written);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
